// File: rtl/ps2_kbd_rx_if.sv
// ps2_kbd_rx_if
//   CPU-side bus/interrupt signals of the PS/2 keyboard receiver.
//   Handshake: `ready` is high while the FIFO holds at least one byte and
//   `data_out` then shows the head byte. A cycle with `rd` high while
//   `ready` is high consumes that byte; `rd` while `ready` is low is ignored.
//   Signals:
//     rd        CPU -> rx   pop strobe
//     clr_ovf   CPU -> rx   clear sticky overflow flag
//     data_out  rx  -> CPU  FIFO head byte (8'h00 when empty)
//     ready     rx  -> CPU  FIFO non-empty
//     int_req   rx  -> CPU  level interrupt, equals ready
//     frame_err rx  -> CPU  one-cycle pulse per rejected frame
//     overflow  rx  -> CPU  sticky, a good byte was dropped on a full FIFO
interface ps2_kbd_rx_if;
  logic       rd;
  logic       clr_ovf;
  logic [7:0] data_out;
  logic       ready;
  logic       int_req;
  logic       frame_err;
  logic       overflow;

  modport master (
    output rd, clr_ovf,
    input  data_out, ready, int_req, frame_err, overflow
  );

  modport slave (
    input  rd, clr_ovf,
    output data_out, ready, int_req, frame_err, overflow
  );
endinterface

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx
//   Receive-only PS/2 keyboard interface. Synchronizes and deglitches the raw
//   ps2_clk/ps2_data pins, decodes 11-bit frames (start, 8 data LSB first,
//   odd parity, stop) and queues good bytes in a fall-through FIFO.
//   Ports:
//     clk, rst      system clock, synchronous active-high reset
//     ps2_clk       raw PS/2 clock pin (asynchronous)
//     ps2_data      raw PS/2 data pin (asynchronous)
//     bus           CPU-side signals (see ps2_kbd_rx_if)
//     dbg_state_o   current receiver FSM state
module ps2_kbd_rx #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_kbd_rx_if.slave       bus,
  output logic [1:0]        dbg_state_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- input synchronizers and glitch filters ----------------
  // Bit 0 = ps2_clk, bit 1 = ps2_data.
  logic [1:0]    s1_q, s2_q;
  logic [1:0]    filt_q, filt_d;
  logic [FW-1:0] cnt_q [2];
  logic [FW-1:0] cnt_d [2];

  always_comb begin
    filt_d = filt_q;
    for (int p = 0; p < 2; p++) begin
      cnt_d[p] = '0;
      if (s2_q[p] != filt_q[p]) begin
        // The FILTER_LEN-th consecutive differing sample flips the output.
        if (cnt_q[p] == FW'(FILTER_LEN - 1)) begin
          filt_d[p] = s2_q[p];
        end else begin
          cnt_d[p] = cnt_q[p] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 2'b11;
      s2_q   <= 2'b11;
      filt_q <= 2'b11;
      cnt_q  <= '{default: '0};
    end else begin
      s1_q   <= {ps2_data, ps2_clk};
      s2_q   <= s1_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  // Sample event: the cycle in which filtered ps2_clk is falling.
  logic sample_evt;
  logic bit_in;
  assign sample_evt = filt_q[0] & ~filt_d[0];
  assign bit_in     = filt_q[1];

  // ---------------- frame FSM ----------------
  state_t        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tout_q, tout_d;
  logic          ferr_q, ferr_d;
  logic          push;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tout_d   = '0;
    ferr_d   = 1'b0;
    push     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sample_evt && !bit_in) begin
          state_d  = S_DATA;
          bitcnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (sample_evt) begin
          shift_d  = {bit_in, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (sample_evt) begin
          par_d   = bit_in;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (sample_evt) begin
          if (((^shift_q) ^ par_q) && bit_in) push = 1'b1;
          else                                ferr_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Silent abort of a stalled frame; no error pulse.
    if (state_q != S_IDLE && !sample_evt) begin
      if (tout_q == TW'(TIMEOUT_CYC - 1)) state_d = S_IDLE;
      else                                tout_d  = tout_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tout_q   <= '0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tout_q   <= tout_d;
      ferr_q   <= ferr_d;
    end
  end

  // ---------------- FIFO ----------------
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full, pop, wr_en, ovf_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = bus.rd & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (bus.clr_ovf)                ovf_q <= 1'b0;
      else if (push && full && !pop)  ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  assign bus.data_out  = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.ready     = ~empty;
  assign bus.int_req   = ~empty;
  assign bus.frame_err = ferr_q;
  assign bus.overflow  = ovf_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
module tb_ps2_kbd_rx;
  localparam int DEPTH = 8;
  localparam int FLEN  = 4;
  localparam int TOUT  = 200;
  localparam int HALF  = 16;        // PS/2 clock half period in clk cycles
  localparam int LAT   = 2 + FLEN;  // pin edge -> registered push visible

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk, ps2_data;
  logic [1:0] dbg_state;

  always #10 clk = ~clk;

  ps2_kbd_rx_if bus();

  ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYC(TOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_bad = 0;
  int         err_cnt = 0;
  logic [7:0] exp_q[$];
  bit         exp_ovf = 1'b0;

  always @(posedge clk) if (bus.frame_err === 1'b1) err_cnt = err_cnt + 1;

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(input string nm);
    chk({nm, "_ready"}, bus.ready, (exp_q.size() != 0));
    chk({nm, "_int_req"}, bus.int_req, (exp_q.size() != 0));
    if (exp_q.size() != 0) chk({nm, "_data"}, bus.data_out, exp_q[0]);
    chk({nm, "_overflow"}, bus.overflow, exp_ovf);
  endtask

  task automatic do_pop(input string nm);
    chk({nm, "_ready"}, bus.ready, 1);
    chk({nm, "_data"}, bus.data_out, exp_q.pop_front());
    bus.rd = 1'b1;
    tick(1);
    bus.rd = 1'b0;
  endtask

  // ---------------- driver ----------------
  // mode 0: plain; 1: latency check on the stop edge; 2: rd in push cycle
  task automatic send_bit(input logic b, input int mode, input logic [7:0] lat_exp);
    ps2_data = b;
    tick(HALF / 2);
    ps2_clk = 1'b0;
    if (mode == 1) begin
      tick(LAT - 1);
      chk("lat_early_ready", bus.ready, 0);
      tick(1);
      chk("lat_ready", bus.ready, 1);
      chk("lat_int_req", bus.int_req, 1);
      chk("lat_data", bus.data_out, lat_exp);
      tick(HALF - LAT);
    end else if (mode == 2) begin
      tick(LAT - 1);
      chk("simul_pop_data", bus.data_out, exp_q[0]);
      bus.rd = 1'b1;
      tick(1);
      bus.rd = 1'b0;
      tick(HALF - LAT);
    end else begin
      tick(HALF);
    end
    ps2_clk = 1'b1;
    tick(HALF / 2);
  endtask

  task automatic glitch();
    ps2_clk = 1'b0;
    tick(2);
    ps2_clk = 1'b1;
    tick(4);
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par,
                                             input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int glitch_at, input int mode);
    logic [10:0] bits;
    bits = frame_bits(b, bad_par, bad_stop);
    for (int i = 0; i < 11; i++) begin
      send_bit(bits[i], (i == 10) ? mode : 0, b);
      if (i == glitch_at) glitch();
    end
    tick(8);
    if (mode == 2) void'(exp_q.pop_front());
    if (!bad_par && !bad_stop) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else                      exp_ovf = 1'b1;
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] b;
    bit         bad_par;
    bit         bad_stop;
    bit         exp_err;
    bit         exp_ready;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vt[7];

  initial begin
    int          e0;
    logic [10:0] bits;

    vt[0] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C};
    vt[1] = '{8'h1C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[2] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0};
    vt[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    vt[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
    vt[5] = '{8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vt[6] = '{8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAA};

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    bus.rd = 1'b0; bus.clr_ovf = 1'b0;
    tick(3);
    chk("rst_ready", bus.ready, 0);
    chk("rst_int_req", bus.int_req, 0);
    chk("rst_data", bus.data_out, 8'h00);
    chk("rst_frame_err", bus.frame_err, 0);
    chk("rst_overflow", bus.overflow, 0);
    rst = 1'b0;
    tick(20);

    // table of single frames, FIFO empty before each
    foreach (vt[i]) begin
      e0 = err_cnt;
      send_frame(vt[i].b, vt[i].bad_par, vt[i].bad_stop, -1, (i == 0) ? 1 : 0);
      chk("vec_err", err_cnt - e0, vt[i].exp_err);
      chk("vec_ready", bus.ready, vt[i].exp_ready);
      if (vt[i].exp_ready) begin
        chk("vec_data", bus.data_out, vt[i].exp_data);
        do_pop("vec_pop");
      end
      chk("vec_empty", bus.ready, 0);
    end

    // glitches on ps2_clk: idle, then mid-frame
    e0 = err_cnt;
    glitch();
    tick(20);
    chk("glitch_idle_ready", bus.ready, 0);
    send_frame(8'h3A, 1'b0, 1'b0, 4, 0);
    chk("glitch_err", err_cnt - e0, 0);
    check_state("glitch");
    do_pop("glitch_pop");

    // timeout: abandoned partial frame, then a full frame
    e0 = err_cnt;
    bits = frame_bits(8'h1C, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(bits[i], 0, 8'h00);
    ps2_data = 1'b1;
    tick(TOUT + 10);
    send_frame(8'hF0, 1'b0, 1'b0, -1, 0);
    chk("tout_err", err_cnt - e0, 0);
    chk("tout_data", bus.data_out, 8'hF0);
    do_pop("tout_pop");
    chk("tout_empty", bus.ready, 0);

    // overflow
    for (int k = 1; k <= 9; k++) begin
      send_frame(8'(k), 1'b0, 1'b0, -1, 0);
      if (k == 8) begin
        chk("ovf8_ready", bus.ready, 1);
        chk("ovf8_overflow", bus.overflow, 0);
      end
    end
    chk("ovf9_overflow", bus.overflow, 1);
    for (int k = 0; k < 8; k++) do_pop("ovf_pop");
    chk("ovf_empty", bus.ready, 0);
    bus.clr_ovf = 1'b1;
    tick(1);
    bus.clr_ovf = 1'b0;
    exp_ovf = 1'b0;
    chk("ovf_clr", bus.overflow, 0);

    // push and pop in the same cycle while full
    for (int k = 0; k < 8; k++) send_frame(8'h11 + 8'(k), 1'b0, 1'b0, -1, 0);
    send_frame(8'h5A, 1'b0, 1'b0, -1, 2);
    chk("simul_overflow", bus.overflow, 0);
    for (int k = 0; k < 7; k++) do_pop("simul_pop");
    chk("simul_last", bus.data_out, 8'h5A);
    do_pop("simul_pop_last");
    chk("simul_empty", bus.ready, 0);

    // reset mid-frame with FIFO contents
    send_frame(8'h66, 1'b0, 1'b0, -1, 0);
    bits = frame_bits(8'h1C, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(bits[i], 0, 8'h00);
    rst = 1'b1;
    tick(1);
    chk("mrst_ready", bus.ready, 0);
    chk("mrst_int_req", bus.int_req, 0);
    chk("mrst_data", bus.data_out, 8'h00);
    chk("mrst_overflow", bus.overflow, 0);
    chk("mrst_frame_err", bus.frame_err, 0);
    rst = 1'b0;
    ps2_data = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    tick(10);
    chk("mrst_idle_ready", bus.ready, 0);
    send_frame(8'h77, 1'b0, 1'b0, -1, 0);
    check_state("mrst_after");
    do_pop("mrst_pop");

    // randomized frames against the queue model
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      int         r;
      b  = 8'($urandom_range(0, 255));
      r  = $urandom_range(0, 7);
      e0 = err_cnt;
      send_frame(b, (r == 0), (r == 1), -1, 0);
      chk("rnd_err", err_cnt - e0, (r <= 1));
      check_state("rnd");
      if (r == 7) begin
        bus.clr_ovf = 1'b1;
        tick(1);
        bus.clr_ovf = 1'b0;
        exp_ovf = 1'b0;
        chk("rnd_clr", bus.overflow, 0);
      end
      r = $urandom_range(0, 2);
      for (int k = 0; k < r; k++) if (exp_q.size() != 0) do_pop("rnd_pop");
    end
    while (exp_q.size() != 0) do_pop("rnd_drain");
    check_state("rnd_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
